// File: rtl/misao_alu_pkg.sv
// Shared types for the nibble-serial ALU: opcodes, width codes, FSM states.
// Also holds the seed value for the inter-lane link bit.
package misao_alu_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_INC = 4'd2,
        OP_DEC = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_INV = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } op_t;

    localparam logic [1:0] WS_UL   = 2'd0;
    localparam logic [1:0] WS_LK8  = 2'd1;
    localparam logic [1:0] WS_LK16 = 2'd2;
    localparam logic [1:0] WS_LK32 = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Link seed: carry/borrow/fill for arithmetic and shifts; reserved ops
    // pass carry_in straight through so it becomes carry_out.
    function automatic logic link_init(
        input op_t  op,
        input logic cen,
        input logic ci
    );
        logic v;
        case (op)
            OP_ADD, OP_SUB,
            OP_SHL, OP_SHR: v = cen & ci;
            OP_INC, OP_DEC: v = 1'b1;
            OP_AND, OP_OR,
            OP_XOR, OP_INV: v = 1'b0;
            default:        v = ci;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/misao_alu_nibble.sv
// One 4-bit ALU lane; link carries carry, borrow or shifted-out bit.
// Purely combinational, shared across lanes by the serial top.
module misao_alu_nibble
    import misao_alu_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  op_t              op,
    input  logic             link_in,
    output logic [NIB_W-1:0] res,
    output logic             link_out
);

    logic [NIB_W:0] ext_a;
    logic [NIB_W:0] ext_b;
    logic [NIB_W:0] ext_l;
    logic [NIB_W:0] sum;

    always_comb begin
        ext_a    = {1'b0, a};
        ext_b    = {1'b0, b};
        ext_l    = {{NIB_W{1'b0}}, link_in};
        sum      = '0;
        res      = a;
        link_out = link_in;
        case (op)
            OP_ADD: sum = ext_a + ext_b + ext_l;
            OP_SUB: sum = ext_a - ext_b - ext_l;
            OP_INC: sum = ext_a + ext_l;
            OP_DEC: sum = ext_a - ext_l;
            default: sum = '0;
        endcase
        case (op)
            OP_ADD, OP_SUB,
            OP_INC, OP_DEC: begin
                res      = sum[NIB_W-1:0];
                link_out = sum[NIB_W];
            end
            OP_AND: begin res = a & b; link_out = 1'b0; end
            OP_OR:  begin res = a | b; link_out = 1'b0; end
            OP_XOR: begin res = a ^ b; link_out = 1'b0; end
            OP_INV: begin res = ~a;    link_out = 1'b0; end
            OP_SHL: begin
                res      = {a[NIB_W-2:0], link_in};
                link_out = a[NIB_W-1];
            end
            OP_SHR: begin
                res      = {link_in, a[NIB_W-1:1]};
                link_out = a[0];
            end
            default: begin
                res      = a;
                link_out = link_in;
            end
        endcase
    end

endmodule

// File: rtl/misao_alu_serial.sv
// Nibble-serial ALU: one 4-bit lane per cycle over 1..MAX_LANES lanes.
// SHR walks lanes MSB-first, everything else LSB-first.
module misao_alu_serial #(
    parameter int MAX_LANES = 4,
    parameter int NIB_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [3:0]                 op,
    input  logic [1:0]                 width_sel,
    input  logic                       cen,
    input  logic                       carry_in,
    input  logic [MAX_LANES*NIB_W-1:0] a,
    input  logic [MAX_LANES*NIB_W-1:0] b,
    output logic                       busy,
    output logic                       done,
    output logic [MAX_LANES*NIB_W-1:0] result,
    output logic                       carry_out,
    output logic                       zero
);
    import misao_alu_pkg::*;

    localparam int CNT_W   = $clog2(MAX_LANES) + 1;
    localparam int SEL_MAX = $clog2(MAX_LANES);
    localparam int IDX_W   = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1;

    typedef logic [MAX_LANES-1:0][NIB_W-1:0] lanes_t;

    state_t           state;
    state_t           state_nx;
    op_t              op_r;
    logic [CNT_W-1:0] n_r;
    logic [CNT_W-1:0] n_c;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pos;
    logic [IDX_W-1:0] idx;
    logic [1:0]       sel;
    logic             last;
    lanes_t           a_r;
    lanes_t           b_r;
    lanes_t           acc;
    lanes_t           acc_nx;
    logic             link;
    logic [NIB_W-1:0] lane_res;
    logic             lane_link;

    // Requested widths beyond the instance clamp to the widest lane count.
    always_comb begin
        sel = (width_sel > 2'(SEL_MAX)) ? 2'(SEL_MAX) : width_sel;
        n_c = CNT_W'(1) << sel;
    end

    always_comb begin
        last   = (cnt == n_r - CNT_W'(1));
        pos    = (op_r == OP_SHR) ? (n_r - CNT_W'(1) - cnt) : cnt;
        idx    = pos[IDX_W-1:0];
        acc_nx = acc;
        acc_nx[idx] = lane_res;
    end

    misao_alu_nibble u_nib (
        .a        (a_r[idx]),
        .b        (b_r[idx]),
        .op       (op_r),
        .link_in  (link),
        .res      (lane_res),
        .link_out (lane_link)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_nx = S_DONE;
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Untouched lanes stay zero because acc is cleared at start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r      <= OP_ADD;
            n_r       <= '0;
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            link      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (state == S_IDLE && start) begin
            op_r <= op_t'(op);
            n_r  <= n_c;
            cnt  <= '0;
            a_r  <= a;
            b_r  <= b;
            acc  <= '0;
            link <= link_init(op_t'(op), cen, carry_in);
        end else if (state == S_RUN) begin
            cnt  <= cnt + CNT_W'(1);
            acc  <= acc_nx;
            link <= lane_link;
            if (last) begin
                result    <= acc_nx;
                carry_out <= lane_link;
            end
        end
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_misao_alu_serial.sv
// Scoreboard bench for misao_alu_serial with directed vectors.
// Stimulus pushes expectations; a negedge monitor pops on done.
module tb_misao_alu_serial;
    import misao_alu_pkg::*;

    localparam int ML = 4;
    localparam int W  = ML * 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [1:0]   width_sel = 2'd0;
    logic         cen = 1'b0;
    logic         carry_in = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int id_n  = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        int           cyc;
        int           id;
    } exp_t;

    exp_t q[$];

    misao_alu_serial #(.MAX_LANES(ML), .NIB_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .width_sel (width_sel),
        .cen       (cen),
        .carry_in  (carry_in),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int id,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got %h want %h", nm, id, act, exp);
        end
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 want 0 at cyc %0d",
                         cyc);
            end else begin
                e = q.pop_front();
                chk("result",  e.id, 32'(result),    32'(e.res));
                chk("carry",   e.id, 32'(carry_out), 32'(e.co));
                chk("zero",    e.id, 32'(zero),      32'(e.res == '0));
                chk("latency", e.id, 32'(cyc),       32'(e.cyc));
            end
        end
    end

    // Called at a negedge; n is the hand-derived active lane count.
    task automatic issue(input logic [3:0] o, input logic [1:0] ws,
                         input logic ce, input logic ci,
                         input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [W-1:0] er, input logic eco,
                         input int n, input bit push);
        int t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=1 want 0");
        end
        op        = o;
        width_sel = ws;
        cen       = ce;
        carry_in  = ci;
        a         = aa;
        b         = bb;
        start     = 1'b1;
        if (push) begin
            id_n++;
            q.push_back('{res: er, co: eco, cyc: cyc + n + 1, id: id_n});
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset(input int id);
        chk("rst_busy",  id, 32'(busy),      32'd0);
        chk("rst_done",  id, 32'(done),      32'd0);
        chk("rst_res",   id, 32'(result),    32'd0);
        chk("rst_carry", id, 32'(carry_out), 32'd0);
        chk("rst_zero",  id, 32'(zero),      32'd1);
    endtask

    initial begin
        #2;
        chk_reset(0);
        @(negedge clk);
        rst = 1'b0;

        issue(OP_ADD, WS_UL, 1, 0, 16'h000D, 16'h0005, 16'h0002, 1, 1, 1);

        issue(OP_ADD, WS_LK16, 0, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 4, 1);
        @(negedge clk);
        op    = OP_SUB;
        a     = 16'h1234;
        start = 1'b1;
        chk("busy_run", 0, 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;

        issue(OP_SUB, WS_UL, 1, 0, 16'h0003, 16'h0005, 16'h000E, 1, 1, 1);
        issue(OP_SUB, WS_UL, 1, 1, 16'h0003, 16'h0005, 16'h000D, 1, 1, 1);
        issue(OP_SHL, WS_LK8, 1, 1, 16'hA58F, 16'h0000, 16'h001F, 1, 2, 1);
        issue(OP_SHR, WS_LK8, 0, 1, 16'h331F, 16'h0000, 16'h000F, 1, 2, 1);
        issue(OP_INC, WS_LK8, 1, 1, 16'h12FF, 16'h0000, 16'h0000, 1, 2, 1);
        issue(OP_ADD, WS_LK32, 0, 0, 16'h1234, 16'h1111, 16'h2345, 0, 4, 1);
        issue(OP_AND, WS_LK16, 1, 1, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 4, 1);
        issue(OP_OR,  WS_LK16, 1, 1, 16'h1200, 16'h0034, 16'h1234, 0, 4, 1);
        issue(OP_XOR, WS_LK16, 1, 1, 16'h5A5A, 16'hFFFF, 16'hA5A5, 0, 4, 1);
        issue(OP_INV, WS_LK16, 1, 1, 16'h0F0F, 16'h0000, 16'hF0F0, 0, 4, 1);
        issue(OP_DEC, WS_UL, 1, 1, 16'h7770, 16'h0000, 16'h000F, 1, 1, 1);
        issue(OP_DEC, WS_LK16, 0, 0, 16'h1000, 16'h0000, 16'h0FFF, 0, 4, 1);
        issue(OP_SUB, WS_LK16, 0, 0, 16'h1000, 16'h0001, 16'h0FFF, 0, 4, 1);
        issue(OP_ADD, WS_LK8, 1, 1, 16'h000F, 16'h0001, 16'h0011, 0, 2, 1);
        issue(OP_SHR, WS_LK16, 1, 1, 16'h0002, 16'h0000, 16'h8001, 0, 4, 1);
        issue(4'd12, WS_LK8, 0, 1, 16'hABCD, 16'h0000, 16'h00CD, 1, 2, 1);
        issue(4'd15, WS_UL, 1, 0, 16'hABCD, 16'h0000, 16'h000D, 0, 1, 1);
        drain();

        issue(OP_ADD, WS_LK16, 0, 0, 16'h1111, 16'h2222, 16'h3333, 0, 4, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset(1);
        @(negedge clk);
        rst = 1'b0;
        issue(OP_ADD, WS_LK16, 0, 0, 16'h0001, 16'h0002, 16'h0003, 0, 4, 1);
        drain();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/misao_alu_serial.md
MISAO_ALU_SERIAL -- requirements
Module: misao_alu_serial

Interface
REQ-001 SHALL have parameter MAX_LANES, default 4, meaning the maximum number of 4-bit lanes; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have parameter NIB_W, default 4, meaning the lane width in bits; only the value 4 is supported.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  operation request.
REQ-006 SHALL have port op  input  4  opcode (op_t).
REQ-007 SHALL have port width_sel  input  2  active width: 0=UL (1 lane), 1=LK8 (2 lanes), 2=LK16 (4 lanes), 3=LK32 (8 lanes).
REQ-008 SHALL have port cen  input  1  carry enable.
REQ-009 SHALL have port carry_in  input  1  current carry flag.
REQ-010 SHALL have ports a and b  input  MAX_LANES*NIB_W  accumulator and RS0 operands.
REQ-011 SHALL have ports busy and done  output  1 each; done is a one-cycle completion pulse.
REQ-012 SHALL have port result  output  MAX_LANES*NIB_W  operation result.
REQ-013 SHALL have ports carry_out and zero  output  1 each; zero is high when result==0.

Function
REQ-014 SHALL clamp width_sel to log2(MAX_LANES), giving the active lane count N.
REQ-015 SHALL use states IDLE, RUN and DONE: IDLE with start goes to RUN; RUN after lane N-1 goes to DONE; DONE unconditionally goes to IDLE.
REQ-016 SHALL accept start only in IDLE and SHALL then latch op, N, cen, carry_in, a and b.
REQ-017 SHALL ignore start while busy is high, which is during RUN and DONE.
REQ-018 SHALL process one lane per cycle, completing RUN in exactly N cycles.
REQ-019 SHALL assert done and update result and carry_out in the DONE cycle, N+1 cycles after the start edge.
REQ-020 SHALL hold result and carry_out until the next DONE.
REQ-021 SHALL treat lanes at and above N as zero in result and SHALL ignore the operand bits in those lanes.
REQ-022 SHALL process lanes LSB-first (lane 0 up to lane N-1) for ADD, SUB, INC, DEC, logic ops and SHL.
REQ-023 SHALL process lanes MSB-first (lane N-1 down to lane 0) for SHR.
REQ-024 ADD SHALL compute a+b+(cen&carry_in), with carry_out = carry out of lane N-1.
REQ-025 SUB SHALL compute a-b-(cen&carry_in), with carry_out = borrow out of lane N-1.
REQ-026 INC and DEC SHALL compute a+1 and a-1 and SHALL ignore carry_in; carry_out = final carry or borrow.
REQ-027 AND, OR and XOR SHALL compute a op b per bit, and INV SHALL compute ~a, all with carry_out=0.
REQ-028 SHL SHALL shift in fill=(cen&carry_in) at bit 0, with carry_out = bit 4N-1 of a.
REQ-029 SHR SHALL shift in the same fill at bit 4N-1, with carry_out = bit 0 of a.
REQ-030 Reserved opcodes SHALL produce result=a and carry_out=carry_in, with the same latency as other ops.
REQ-031 The inter-lane carry/borrow/shift bit SHALL be a register that is reset at operation start.

Reset
REQ-032 Asserting rst at any time SHALL immediately force state=IDLE, busy=0, done=0, result=0, carry_out=0 and zero=1.
REQ-033 An in-flight operation SHALL be discarded by reset without a done pulse.
REQ-034 The first rising edge with rst low and start high SHALL be accepted.

Structure
REQ-035 Package misao_alu_pkg SHALL hold op_t (ADD=0, SUB=1, INC=2, DEC=3, AND=4, OR=5, XOR=6, INV=7, SHL=8, SHR=9, 10-15 reserved).
REQ-036 Package misao_alu_pkg SHALL also hold the width_sel encoding constants, the state enum and NIB_W.
REQ-037 The block SHALL instantiate one combinational sub-module, misao_alu_nibble, taking a lane of a and b, op and a link bit, and returning a lane result and a link bit.
REQ-038 The block SHALL size the lane counter $clog2(MAX_LANES)+1 bits wide.

Verification
REQ-039 UL ADD with a=D, b=5, cen=1, carry_in=0 -> result=2, carry_out=1, done two cycles after start.
REQ-040 LK16 ADD with a=FFFF, b=0001, cen=0 -> result=0000, carry_out=1, zero=1, done at cycle 5; a start at cycle 2 is ignored.
REQ-041 UL SUB with a=3, b=5, cen=1, carry_in=0 -> result=E, carry_out=1; repeating with carry_in=1 -> result=D, carry_out=1.
REQ-042 LK8 SHL with a=8F, cen=1, carry_in=1 -> result=1F, carry_out=1; then LK8 SHR with a=1F, cen=0 -> result=0F, carry_out=1.
REQ-043 LK8 INC with a=12FF (MAX_LANES=4) -> result=0000, carry_out=1; LK32 request with MAX_LANES=4 clamps to LK16, done at cycle 5.
REQ-044 rst pulsed at cycle 2 of an LK16 operation -> no done pulse, all outputs at reset values, and the next start completes normally.
